// File: rtl/lenet_mac_accumulator.sv
// LeNet conv/FC MAC accumulator: sums a window of signed products,
// adds bias, optional ReLU, and hands one result downstream.
module lenet_mac_accumulator #(
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 16,
    parameter bit RELU_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [DATA_W-1:0] cfg_bias,
    input  logic              start,
    input  logic              prod_valid,
    input  logic [DATA_W-1:0] prod_data,
    output logic              prod_ready,
    output logic              mul_ce,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    input  logic              res_ready,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FINAL,
        OUT
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] bias_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  count;
    logic [DATA_W-1:0] sum;
    logic              xfer;
    logic              last;

    assign xfer = prod_valid && prod_ready;
    assign last = (count == len_q - LEN_ONE);
    assign sum  = acc + bias_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake/stall outputs
    always_comb begin
        state_d    = state_q;
        prod_ready = 1'b0;
        busy       = 1'b1;
        mul_ce     = 1'b1;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = (cfg_len != '0) ? ACCUM : FINAL;
                end
            end
            ACCUM: begin
                prod_ready = 1'b1;
                // Stall term kept for a future non-always-ready ACCUM.
                if (prod_valid && !prod_ready) begin
                    mul_ce = 1'b0;
                end
                if (xfer && last) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                mul_ce  = 1'b0;
                state_d = OUT;
            end
            OUT: begin
                mul_ce = 1'b0;
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Window config capture, accumulation and result register
    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            bias_q    <= '0;
            len_q     <= '0;
            count     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        len_q  <= cfg_len;
                        bias_q <= cfg_bias;
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                ACCUM: begin
                    if (xfer) begin
                        acc   <= acc + prod_data;
                        count <= count + LEN_ONE;
                    end
                end
                FINAL: begin
                    res_valid <= 1'b1;
                    res_data  <= (RELU_EN && sum[DATA_W-1]) ? '0 : sum;
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
